// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad (PmodKYPD style) and turns debounced
// key presses into hex codes.  One row is driven low at a time; the row is
// held for one scan tick before its columns are sampled.  Once a column is
// seen low, the row stays held while the press is debounced, reported, and
// then the release is debounced.  Each accepted key is shifted into an
// 8-digit register whose nibbles feed a 7-segment display controller
// (digits[31:28] -> seg7 ... digits[3:0] -> seg0).
//
// Parameters
//   SCAN_DIV        clk cycles per scan tick
//   DEBOUNCE_TICKS  consecutive identical tick samples needed to accept a
//                   press or a release (must be >= 2)
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high; clears all state
//   cols       in   4   column sense lines, active-low, asynchronous to clk
//   clear      in   1   synchronous; zeroes digits
//   rows       out  4   row drive lines, active-low, exactly one low
//   key_code   out  4   hex code of the last accepted key
//   key_valid  out  1   one-clk pulse per accepted key press
//   key_down   out  1   high while the accepted key is held
//   digits     out  32  last 8 accepted keys, newest in [3:0]
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cols,
  input  logic        clear,
  output logic [3:0]  rows,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [31:0] digits
);

  // state      | meaning
  // -----------+---------------------------------------------------------
  // ST_SCAN    | rotating rows, waiting for any column to go low
  // ST_DEBOUNCE| row held, counting consecutive low samples of one column
  // ST_PRESSED | key accepted and reported, waiting for a high sample
  // ST_RELEASE | row held, counting consecutive high samples of the column
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_DONE  = CNT_W'(DEBOUNCE_TICKS);

  logic [3:0]       cols_meta;
  logic [3:0]       cols_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       state;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_nxt;
  logic             col_hit;
  logic             col_high;

  // Lowest-index low column wins when several keys in the row are down.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // PmodKYPD legend: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Column lines are idle-high, so the synchronizer resets to all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols_meta <= 4'hF;
      cols_sync <= 4'hF;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick     = (div_cnt == DIV_LAST);
  assign col_hit  = ~&cols_sync;
  assign col_high = cols_sync[col_idx];
  assign db_nxt   = db_cnt + CNT_W'(1);
  assign rows     = ~(4'b0001 << row_idx);

  // The counter stops at DEBOUNCE_TICKS and is cleared on every exit, so it
  // never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (col_hit) begin
              col_idx <= low_col(cols_sync);
              db_cnt  <= CNT_W'(1);
              state   <= ST_DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (!col_high) begin
              if (db_nxt == DB_DONE) begin
                db_cnt    <= '0;
                state     <= ST_PRESSED;
                key_code  <= key_lookup(row_idx, col_idx);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
              end else begin
                db_cnt <= db_nxt;
              end
            end else begin
              // Chatter: go back to sampling the same row on the next tick.
              db_cnt <= '0;
              state  <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (col_high) begin
              db_cnt <= CNT_W'(1);
              state  <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (col_high) begin
              if (db_nxt == DB_DONE) begin
                db_cnt   <= '0;
                state    <= ST_SCAN;
                key_down <= 1'b0;
                row_idx  <= row_idx + 2'd1;
              end else begin
                db_cnt <= db_nxt;
              end
            end else begin
              // Release bounce: the key is still the same press, no new pulse.
              db_cnt <= '0;
              state  <= ST_PRESSED;
            end
          end
          default: begin
            db_cnt <= '0;
            state  <= ST_SCAN;
          end
        endcase
      end
    end
  end

  // key_code is already updated while key_valid is high, so the shift picks
  // up the new code.  clear overrides a coincident shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= 32'h0;
    end else if (clear) begin
      digits <= 32'h0;
    end else if (key_valid) begin
      digits <= {digits[27:0], key_code};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [31:0] digits;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .clear     (clear),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .digits    (digits)
  );

  // Behavioural keypad: one key, its column is pulled low only while its row
  // is driven low.
  logic       key_on = 1'b0;
  logic [1:0] key_r  = 2'd0;
  logic [1:0] key_c  = 2'd0;

  always_comb begin
    cols = 4'hF;
    if (key_on && (rows[key_r] == 1'b0)) cols[key_c] = 1'b0;
  end

  // Reference scan-tick phase: the edge after tb_div==3 is a tick edge.
  logic [1:0] tb_div;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_div <= 2'd0;
    else       tb_div <= tb_div + 2'd1;
  end

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] digits;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          valid_count = 0;
  logic [31:0] exp_digits = 32'h0;

  // Scoreboard monitor
  logic        kv_prev = 1'b0;
  logic        dig_pending = 1'b0;
  logic [31:0] pend_digits = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (dig_pending) begin
      checks++;
      if (digits !== pend_digits) begin
        errors++;
        $display("FAIL digits_after_key: got %h expected %h", digits, pend_digits);
      end
      dig_pending = 1'b0;
    end
    if (key_valid === 1'b1) begin
      valid_count++;
      checks++;
      if (kv_prev) begin
        errors++;
        $display("FAIL key_valid_width: key_valid high for more than one clk");
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: got code %h expected no key", key_code);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (key_code !== e.code) begin
          errors++;
          $display("FAIL key_code: got %h expected %h", key_code, e.code);
        end
        checks++;
        if (key_down !== 1'b1) begin
          errors++;
          $display("FAIL key_down_at_valid: got %b expected 1", key_down);
        end
        dig_pending = 1'b1;
        pend_digits = e.digits;
      end
    end
    kv_prev = key_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns half a clock after the next tick edge.
  task automatic wait_tick();
    while (tb_div != 2'd3) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_down(input logic lvl, input string name);
    int n = 0;
    while (key_down !== lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_down !== lvl) begin
      errors++;
      $display("FAIL %s: key_down got %b expected %b (timeout)", name, key_down, lvl);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_t e;
    exp_digits = {exp_digits[27:0], code};
    e.code   = code;
    e.digits = exp_digits;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  task automatic tap(input logic [1:0] r, input logic [1:0] c, input logic [3:0] code);
    expect_key(code);
    press(r, c);
    wait_down(1'b1, "tap_press");
    wait_tick();
    key_on = 1'b0;
    wait_down(1'b0, "tap_release");
    wait_tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   v0;
    int   n;
    exp_t e;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_rows", 32'(rows), 32'(4'b1110));
    chk("reset_key_code", 32'(key_code), 32'h0);
    chk("reset_key_valid", 32'(key_valid), 32'h0);
    chk("reset_key_down", 32'(key_down), 32'h0);
    chk("reset_digits", digits, 32'h0);
    reset = 1'b0;

    // 1. Idle scanning, one row change per tick
    for (int i = 0; i < 8; i++) begin
      logic [3:0] want;
      want = ~(4'b0001 << ((i + 1) % 4));
      wait_tick();
      chk("idle_rows_at_tick", 32'(rows), 32'(want));
      repeat (3) @(negedge clk);
      chk("idle_rows_hold", 32'(rows), 32'(want));
    end
    chk("idle_valid_count", 32'(valid_count), 32'h0);
    chk("idle_key_down", 32'(key_down), 32'h0);
    chk("idle_digits", digits, 32'h0);

    // 2. Single key '6' at r1/c2
    expect_key(4'h6);
    press(2'd1, 2'd2);
    wait_down(1'b1, "key6_press");
    wait_tick();
    key_on = 1'b0;
    wait_tick();
    wait_tick();
    chk("key6_down_before_release_done", 32'(key_down), 32'h1);
    wait_tick();
    chk("key6_down_after_release", 32'(key_down), 32'h0);
    chk("key6_rows_resume", 32'(rows), 32'(4'b1011));
    chk("key6_digits", digits, 32'h0000_0006);

    // 3. Nine keys, digits keeps the last eight
    v0 = valid_count;
    tap(2'd0, 2'd0, 4'h1);
    tap(2'd0, 2'd1, 4'h2);
    tap(2'd0, 2'd3, 4'hA);
    tap(2'd3, 2'd3, 4'hD);
    tap(2'd0, 2'd2, 4'h3);
    tap(2'd1, 2'd0, 4'h4);
    tap(2'd2, 2'd0, 4'h7);
    tap(2'd3, 2'd0, 4'h0);
    tap(2'd3, 2'd2, 4'hE);
    chk("nine_keys_valid_count", 32'(valid_count - v0), 32'd9);
    chk("nine_keys_digits", digits, 32'h2AD3_470E);

    // 4a. Press chatter: low for two samples only
    v0 = valid_count;
    for (int k = 0; k < 8 && rows != 4'b1101; k++) wait_tick();
    chk("chatter_row_align", 32'(rows), 32'(4'b1101));
    press(2'd1, 2'd1);
    wait_tick();
    wait_tick();
    key_on = 1'b0;
    repeat (4) wait_tick();
    chk("chatter_no_valid", 32'(valid_count - v0), 32'h0);
    chk("chatter_key_down", 32'(key_down), 32'h0);
    chk("chatter_scan_resumes", 32'(rows), 32'(4'b1110));

    // 4b. One-tick bounce during release of '8'
    v0 = valid_count;
    expect_key(4'h8);
    press(2'd2, 2'd1);
    wait_down(1'b1, "key8_press");
    wait_tick();
    key_on = 1'b0;
    wait_tick();
    key_on = 1'b1;
    wait_tick();
    wait_tick();
    chk("bounce_key_down_held", 32'(key_down), 32'h1);
    key_on = 1'b0;
    wait_down(1'b0, "key8_release");
    wait_tick();
    chk("bounce_single_valid", 32'(valid_count - v0), 32'h1);
    chk("bounce_digits", digits, 32'hAD34_70E8);

    // 5a. clear coincident with key_valid for '9'
    exp_digits = 32'h0;
    e.code   = 4'h9;
    e.digits = 32'h0;
    exp_q.push_back(e);
    press(2'd2, 2'd2);
    n = 0;
    while (key_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("key9_valid_seen", 32'(key_valid), 32'h1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("key9_key_code", 32'(key_code), 32'h9);
    key_on = 1'b0;
    wait_down(1'b0, "key9_release");
    wait_tick();
    chk("key9_digits_cleared", digits, 32'h0);

    // 5b. clear on its own
    tap(2'd2, 2'd0, 4'h7);
    chk("before_clear_digits", digits, 32'h0000_0007);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_alone_digits", digits, 32'h0);
    exp_digits = 32'h0;

    // 6. reset while 'F' is held in PRESSED
    expect_key(4'hF);
    press(2'd3, 2'd1);
    wait_down(1'b1, "keyF_press");
    wait_tick();
    wait_tick();
    reset = 1'b1;
    #1;
    chk("midreset_rows", 32'(rows), 32'(4'b1110));
    chk("midreset_key_code", 32'(key_code), 32'h0);
    chk("midreset_key_valid", 32'(key_valid), 32'h0);
    chk("midreset_key_down", 32'(key_down), 32'h0);
    chk("midreset_digits", digits, 32'h0);
    exp_digits = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = valid_count;
    expect_key(4'hF);
    wait_down(1'b1, "keyF_redetect");
    repeat (10) wait_tick();
    chk("keyF_still_down", 32'(key_down), 32'h1);
    key_on = 1'b0;
    wait_down(1'b0, "keyF_release");
    wait_tick();
    chk("keyF_once", 32'(valid_count - v0), 32'h1);
    chk("keyF_digits", digits, 32'h0000_000F);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
